// File: rtl/x_counter_pkg.sv
// Shared types for the x_counter family: count modes, FSM states, direction encoding.
// Optional prescaler build switch used by the family: X_COUNTER_PRESCALE_EN.
package x_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2
   } mode_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // The reserved encoding 3 falls back to wrap-around counting.
   function automatic mode_t decode_mode(input logic [1:0] raw);
      case (raw)
         2'd1:    return MODE_SAT;
         2'd2:    return MODE_ONESHOT;
         default: return MODE_WRAP;
      endcase
   endfunction

endpackage

// File: rtl/x_counter_prescaler.sv
// Step-tick generator: one tick every PRESCALE enabled cycles.
// Only compiled and instantiated when X_COUNTER_PRESCALE_EN is defined.
`ifdef X_COUNTER_PRESCALE_EN
module x_counter_prescaler
   import x_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   input  logic i_advance,
   output logic o_tick
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] ticks;

   assign o_tick = (ticks == LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart) begin
         ticks <= '0;
      end else if (i_advance) begin
         ticks <= (ticks == LAST) ? '0 : ticks + CW'(1);
      end
   end

endmodule
`endif

// File: rtl/x_counter_param.sv
// WIDTH-bit up/down counter with modulus MAX+1, load/clear and wrap/saturate/one-shot modes.
// Define X_COUNTER_PRESCALE_EN to step only every PRESCALE enabled cycles.
module x_counter_param
   import x_counter_pkg::*;
#(
   parameter int unsigned       WIDTH    = 16,
   parameter logic [WIDTH-1:0]  MAX      = '1,
   parameter int unsigned       PRESCALE = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic [1:0]       i_mode,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_done
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("x_counter_param: WIDTH out of range");
   end
   if (MAX == '0) begin : g_bad_max
      $error("x_counter_param: MAX must be at least 1");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("x_counter_param: PRESCALE must be at least 1");
   end

   state_t           state, state_nx;
   mode_t            mode;
   logic [WIDTH-1:0] count, count_nx;
   logic             tc, tc_nx;
   logic             done, done_nx;
   logic [WIDTH-1:0] term, stepped, load_clamped;
   logic             tick, step, at_term, moves;

   assign mode = decode_mode(i_mode);

`ifdef X_COUNTER_PRESCALE_EN
   x_counter_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_restart(i_clr || i_load),
      .i_advance(i_en && (state == ST_RUN)),
      .o_tick   (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // Next-count datapath; arithmetic is modulo MAX+1 in both directions.
   always_comb begin
      term         = (i_dir == DIR_DOWN) ? '0 : MAX;
      at_term      = (count == term);
      step         = (state == ST_RUN) && i_en && tick;
      moves        = step && !((mode == MODE_SAT) && at_term);
      load_clamped = (i_load_val > MAX) ? MAX : i_load_val;
      if (i_dir == DIR_DOWN) begin
         stepped = (count == '0) ? MAX : count - WIDTH'(1);
      end else begin
         stepped = (count == MAX) ? '0 : count + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (i_clr || i_load) begin
         state_nx = ST_RUN;
      end else if (moves && (mode == MODE_ONESHOT) && (stepped == term)) begin
         state_nx = ST_HALT;
      end
   end

   always_comb begin
      count_nx = count;
      tc_nx    = 1'b0;
      done_nx  = done;
      if (i_clr) begin
         count_nx = '0;
         done_nx  = 1'b0;
      end else if (i_load) begin
         count_nx = load_clamped;
         done_nx  = 1'b0;
      end else if (moves) begin
         count_nx = stepped;
         tc_nx    = (stepped == term);
         if ((mode == MODE_ONESHOT) && (stepped == term)) begin
            done_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count <= '0;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else begin
         count <= count_nx;
         tc    <= tc_nx;
         done  <= done_nx;
      end
   end

   assign o_count = count;
   assign o_tc    = tc;
   assign o_done  = done;

endmodule

// File: tb/tb_x_counter_param.sv
// Bench for x_counter_param: directed vector table, one-shot/prescale sequences and a
// randomized run against an arithmetic reference model (two instances, MAX=9 and MAX=5).
module tb_x_counter_param;

`ifdef X_COUNTER_PRESCALE_EN
   localparam int EFF_P = 3;
`else
   localparam int EFF_P = 1;
`endif

   logic       clk;
   logic       rst, en, dir, clr, load;
   logic [1:0] mode;
   logic [3:0] lv;
   logic [3:0] cnt_a, cnt_b;
   logic       tc_a, tc_b, done_a, done_b;

   int tests = 0;
   int fails = 0;

   int m_cnt  [2];
   int m_tc   [2];
   int m_done [2];
   int m_halt [2];
   int m_tick [2];

   x_counter_param #(.WIDTH(4), .MAX(4'd9), .PRESCALE(3)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_mode(mode),
      .i_clr(clr), .i_load(load), .i_load_val(lv),
      .o_count(cnt_a), .o_tc(tc_a), .o_done(done_a)
   );

   x_counter_param #(.WIDTH(4), .MAX(4'd5), .PRESCALE(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_mode(mode),
      .i_clr(clr), .i_load(load), .i_load_val(lv),
      .o_count(cnt_b), .o_tc(tc_b), .o_done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, dir;
      logic [1:0] mode;
      logic       clr, load;
      logic [3:0] lv;
      int         cnt;
      logic       tc, done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic e, input logic d, input logic [1:0] m,
                               input logic c, input logic l, input logic [3:0] v,
                               input int xc, input logic xt, input logic xd);
      vec_t t;
      t.rst = r; t.en = e; t.dir = d; t.mode = m; t.clr = c; t.load = l; t.lv = v;
      t.cnt = xc; t.tc = xt; t.done = xd;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic d, input logic [1:0] m,
                        input logic c, input logic l, input logic [3:0] v);
      rst = r; en = e; dir = d; mode = m; clr = c; load = l; lv = v;
   endtask

   // Reference: count as an integer modulo max+1, following the priority and mode rules.
   task automatic model_step(input int idx);
      int mx, term, md;
      bit fire;
      mx   = (idx == 0) ? 9 : 5;
      term = dir ? 0 : mx;
      md   = (mode == 2'd3) ? 0 : int'(mode);
      m_tc[idx] = 0;
      if (rst) begin
         m_cnt[idx] = 0; m_done[idx] = 0; m_halt[idx] = 0; m_tick[idx] = 0;
      end else if (clr) begin
         m_cnt[idx] = 0; m_done[idx] = 0; m_halt[idx] = 0; m_tick[idx] = 0;
      end else if (load) begin
         m_cnt[idx]  = (int'(lv) > mx) ? mx : int'(lv);
         m_done[idx] = 0; m_halt[idx] = 0; m_tick[idx] = 0;
      end else if (m_halt[idx] == 0 && en) begin
         fire = 1'b0;
         if (m_tick[idx] == EFF_P - 1) begin
            fire = 1'b1;
            m_tick[idx] = 0;
         end else begin
            m_tick[idx]++;
         end
         if (fire && !(md == 1 && m_cnt[idx] == term)) begin
            m_cnt[idx] = dir ? (m_cnt[idx] + mx) % (mx + 1) : (m_cnt[idx] + 1) % (mx + 1);
            if (m_cnt[idx] == term) begin
               m_tc[idx] = 1;
               if (md == 2) begin
                  m_halt[idx] = 1;
                  m_done[idx] = 1;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk("model.a.count", int'(cnt_a),  m_cnt[0]);
      chk("model.a.tc",    int'(tc_a),   m_tc[0]);
      chk("model.a.done",  int'(done_a), m_done[0]);
      chk("model.b.count", int'(cnt_b),  m_cnt[1]);
      chk("model.b.tc",    int'(tc_b),   m_tc[1]);
      chk("model.b.done",  int'(done_b), m_done[1]);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);

`ifdef X_COUNTER_PRESCALE_EN
      cycle();
      chk("ps.reset", int'(cnt_a), 0);
      for (int k = 1; k <= 9; k++) begin
         drive(0, 1, 0, 0, 0, 0, 0);
         cycle();
         chk("ps.run", int'(cnt_a), k / 3);
      end
      cycle();
      chk("ps.pre_load", int'(cnt_a), 3);
      drive(0, 1, 0, 0, 0, 1, 4'd5);
      cycle();
      chk("ps.load", int'(cnt_a), 5);
      for (int k = 1; k <= 6; k++) begin
         drive(0, 1, 0, 0, 0, 0, 0);
         cycle();
         chk("ps.restart", int'(cnt_a), 5 + k / 3);
      end
`else
      // rst en dir mode clr load lv | count tc done   (instance with MAX=9)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 12; k++)
         tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, k % 10, (k == 9), 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd2, 2, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2, 0, 1, 4'd7, 7, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 8, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 9, 1, 1));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 9, 0, 1));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 9, 0, 1));
      tbl.push_back(mk(0, 1, 0, 2, 0, 1, 4'd1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 1, 1, 4'd7, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 4'd7, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd15, 9, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 9, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 9, 1, 0));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 9, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 9, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2, 0, 1, 4'd8, 8, 0, 0));
      tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 9, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].clr, tbl[i].load, tbl[i].lv);
         cycle();
         chk($sformatf("vec%0d.count", i), int'(cnt_a),  tbl[i].cnt);
         chk($sformatf("vec%0d.tc", i),    int'(tc_a),   int'(tbl[i].tc));
         chk($sformatf("vec%0d.done", i),  int'(done_a), int'(tbl[i].done));
      end

      // One-shot on the MAX=5 instance: load 3, count to 5, hold, reload resumes.
      drive(0, 0, 0, 2, 0, 1, 4'd3);
      cycle();
      chk("os.load", int'(cnt_b), 3);
      drive(0, 1, 0, 2, 0, 0, 0);
      cycle();
      chk("os.step4", int'(cnt_b), 4);
      cycle();
      chk("os.step5", int'(cnt_b), 5);
      chk("os.tc", int'(tc_b), 1);
      chk("os.done", int'(done_b), 1);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("os.held", int'(cnt_b), 5);
         chk("os.held_done", int'(done_b), 1);
      end
      drive(0, 0, 0, 2, 0, 1, 4'd1);
      cycle();
      chk("os.reload", int'(cnt_b), 1);
      chk("os.reload_done", int'(done_b), 0);
      drive(0, 1, 0, 2, 0, 0, 0);
      cycle();
      chk("os.resume", int'(cnt_b), 2);
`endif

      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 29) == 0), ($urandom_range(0, 11) == 0),
               4'($urandom_range(0, 15)));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
